// File: rtl/fb_rect_writer.sv
// Rectangle-fill blitter: writes a 4-bit palette index into every pixel of a clipped
// rectangle of the 640x480 framebuffer SRAM, one pixel per granted cycle.
module fb_rect_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [9:0]  width,
  input  logic [9:0]  height,
  input  logic [3:0]  color,
  input  logic        sram_gnt,
  output logic        busy,
  output logic        done,
  output logic        sram_we,
  output logic [19:0] sram_addr,
  output logic [3:0]  sram_data,
  output logic [1:0]  state_dbg
);

  // Handshake: start is a level sampled only in IDLE (never queued); a pixel is
  // transferred in exactly those cycles where sram_we is high, which requires
  // WRITE state and sram_gnt=1 in that same cycle. With gnt=0 nothing advances.

  localparam logic [10:0] H_LIM      = 11'(H_RES);
  localparam logic [10:0] V_LIM      = 11'(V_RES);
  localparam logic [19:0] ROW_STRIDE = 20'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [9:0]  x0_q;
  logic [9:0]  y0_q;
  logic [9:0]  w_q;
  logic [9:0]  h_q;
  logic [3:0]  color_q;
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic [9:0]  cur_x;
  logic [9:0]  cur_y;
  logic [19:0] row_base;

  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic [19:0] y0_wide;
  logic        empty_cmd;
  logic        x_last;
  logic        y_last;
  logic        write_fire;

  // 11-bit sums so x0+width can never wrap before clipping.
  assign x_sum   = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum   = {1'b0, y0_q} + {1'b0, h_q};
  assign y0_wide = {10'd0, y0_q};

  assign empty_cmd = (w_q == 10'd0) || (h_q == 10'd0) ||
                     ({1'b0, x0_q} >= H_LIM) || ({1'b0, y0_q} >= V_LIM);

  assign x_last     = ({1'b0, cur_x} == (x_end - 11'd1));
  assign y_last     = ({1'b0, cur_y} == (y_end - 11'd1));
  assign write_fire = (state == S_WRITE) && sram_gnt && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_SETUP;
      end
      S_SETUP: begin
        state_next = empty_cmd ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        if (sram_gnt && x_last && y_last) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            w_q     <= width;
            h_q     <= height;
            color_q <= color;
          end
        end
        S_SETUP: begin
          x_end    <= (x_sum > H_LIM) ? H_LIM : x_sum;
          y_end    <= (y_sum > V_LIM) ? V_LIM : y_sum;
          cur_x    <= x0_q;
          cur_y    <= y0_q;
          // y*640 as two shifts; fixes the stride at 640.
          row_base <= (y0_wide << 9) + (y0_wide << 7);
        end
        S_WRITE: begin
          if (sram_gnt) begin
            if (x_last) begin
              if (!y_last) begin
                cur_x    <= x0_q;
                cur_y    <= cur_y + 10'd1;
                row_base <= row_base + ROW_STRIDE;
              end
            end else begin
              cur_x <= cur_x + 10'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are forced low while Reset is high so nothing leaks during reset.
  assign busy      = !Reset && ((state == S_SETUP) || (state == S_WRITE));
  assign done      = !Reset && (state == S_DONE);
  assign sram_we   = write_fire;
  assign sram_addr = write_fire ? (row_base + {10'd0, cur_x}) : 20'd0;
  assign sram_data = write_fire ? color_q : 4'd0;
  assign state_dbg = state;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: per-scenario tasks compare the observed write stream and
// timing against a rectangle model computed from pixel coordinates.
module tb_fb_rect_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  x0 = '0;
  logic [9:0]  y0 = '0;
  logic [9:0]  width = '0;
  logic [9:0]  height = '0;
  logic [3:0]  color = '0;
  logic        sram_gnt = 1'b0;
  logic        busy;
  logic        done;
  logic        sram_we;
  logic [19:0] sram_addr;
  logic [3:0]  sram_data;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int          obs_cyc[$];
  int          done_cyc;
  int          done_cnt;
  int          gnt_viol;
  int          idle_viol;
  int          post_busy;
  logic        busy_k1;

  fb_rect_writer dut (
    .Clk(clk), .Reset(reset), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .color(color), .sram_gnt(sram_gnt),
    .busy(busy), .done(done), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_data(sram_data), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: every pixel of the rectangle that lies on screen, row-major.
  task automatic build_exp(input int x, input int y, input int w, input int h, input int c);
    int xe;
    int ye;
    exp_q.delete();
    xe = (x + w > 640) ? 640 : x + w;
    ye = (y + h > 480) ? 480 : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        exp_q.push_back({20'(yy * 640 + xx), 4'(c)});
  endtask

  function automatic logic gnt_for(input int mode, input int k);
    logic [5:0] pat;
    pat = 6'b101001;  // bit i = grant for cycle index i mod 6: 1,0,0,1,0,1
    case (mode)
      0: return 1'b1;
      1: return pat[k % 6];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Drives one command and records everything the DUT does until two cycles after done.
  // restart_at > 0: second start with a different command in that cycle; -1: start in the done cycle.
  task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                         input int gmode, input int restart_at);
    int k;
    obs_q.delete();
    obs_cyc.delete();
    done_cyc = -1; done_cnt = 0; gnt_viol = 0; idle_viol = 0; post_busy = 0; busy_k1 = 1'b0;
    @(negedge clk);
    x0 = 10'(x); y0 = 10'(y); width = 10'(w); height = 10'(h); color = 4'(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (k < 3000) begin
      sram_gnt = gnt_for(gmode, k);
      if (k == restart_at) begin
        start = 1'b1; x0 = 10'd0; y0 = 10'd0; width = 10'd4; height = 10'd4; color = 4'(c) ^ 4'hF;
      end
      @(negedge clk);
      if (k == 1) busy_k1 = busy;
      if (sram_we) begin
        obs_q.push_back({sram_addr, sram_data});
        obs_cyc.push_back(k);
        if (!sram_gnt) gnt_viol++;
      end else if (sram_addr != 20'd0 || sram_data != 4'd0) begin
        idle_viol++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
        if (busy) idle_viol++;
        if (restart_at < 0) begin
          start = 1'b1; x0 = 10'd0; y0 = 10'd0; width = 10'd3; height = 10'd3; color = 4'hE;
        end
      end
      if (done_cyc >= 0 && k > done_cyc && busy) post_busy++;
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
      k++;
    end
    sram_gnt = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; sram_gnt = 1'b1; width = 10'd4; height = 10'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, sram_we, sram_addr, sram_data} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_during: got busy=%b done=%b we=%b addr=%0d data=%0d expected all 0",
               busy, done, sram_we, sram_addr, sram_data);
    end
    start = 1'b0; sram_gnt = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, sram_we, sram_addr, sram_data} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_after: got busy=%b done=%b we=%b addr=%0d data=%0d expected all 0",
               busy, done, sram_we, sram_addr, sram_data);
    end
  endtask

  task automatic test_basic();
    logic [23:0] got;
    build_exp(10, 20, 2, 2, 5);
    run_cmd(10, 20, 2, 2, 5, 0, 0);
    n_checks++;
    if (obs_q.size() !== 4) begin
      n_fail++; $display("FAIL basic_count: got %0d writes expected 4", obs_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_pix%0d: got %h expected %h", i, got, exp_q[i]);
      end
      n_checks++;
      if (i < obs_cyc.size() && obs_cyc[i] !== 2 + i) begin
        n_fail++; $display("FAIL basic_cyc%0d: got %0d expected %0d", i, obs_cyc[i], 2 + i);
      end
    end
    n_checks++;
    if (busy_k1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", busy_k1);
    end
    n_checks++;
    if (done_cyc !== 6 || done_cnt !== 1 || post_busy !== 0 || idle_viol !== 0) begin
      n_fail++;
      $display("FAIL basic_done: got cyc=%0d cnt=%0d post_busy=%0d idle_viol=%0d expected 6 1 0 0",
               done_cyc, done_cnt, post_busy, idle_viol);
    end
  endtask

  task automatic test_clip();
    logic [23:0] got;
    build_exp(638, 479, 5, 5, 3);
    run_cmd(638, 479, 5, 5, 3, 0, 0);
    n_checks++;
    if (obs_q.size() !== 2) begin
      n_fail++; $display("FAIL clip_count: got %0d writes expected 2", obs_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL clip_pix%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    n_checks++;
    if (done_cyc !== 4 || done_cnt !== 1) begin
      n_fail++; $display("FAIL clip_done: got cyc=%0d cnt=%0d expected 4 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_empty();
    int tx[4];
    int ty[4];
    int tw[4];
    int th[4];
    tx = '{5, 700, 0, 100}; ty = '{5, 0, 480, 0}; tw = '{0, 3, 3, 4}; th = '{2, 3, 3, 0};
    for (int t = 0; t < 4; t++) begin
      run_cmd(tx[t], ty[t], tw[t], th[t], 7, 0, 0);
      n_checks++;
      if (obs_q.size() !== 0 || done_cyc !== 2 || done_cnt !== 1) begin
        n_fail++;
        $display("FAIL empty%0d: got writes=%0d done_cyc=%0d done_cnt=%0d expected 0 2 1",
                 t, obs_q.size(), done_cyc, done_cnt);
      end
    end
  endtask

  task automatic test_throttle();
    logic [23:0] got;
    build_exp(0, 0, 3, 2, 9);
    run_cmd(0, 0, 3, 2, 9, 1, 0);
    n_checks++;
    if (obs_q.size() !== 6 || gnt_viol !== 0 || idle_viol !== 0) begin
      n_fail++;
      $display("FAIL throttle_count: got writes=%0d gnt_viol=%0d idle_viol=%0d expected 6 0 0",
               obs_q.size(), gnt_viol, idle_viol);
    end
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL throttle_pix%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    n_checks++;
    if (obs_cyc.size() == 0 || done_cyc !== obs_cyc[obs_cyc.size() - 1] + 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL throttle_done: got done_cyc=%0d cnt=%0d", done_cyc, done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    logic [23:0] got;
    build_exp(100, 50, 3, 3, 6);
    run_cmd(100, 50, 3, 3, 6, 0, 4);
    n_checks++;
    if (obs_q.size() !== exp_q.size() || done_cnt !== 1 || post_busy !== 0) begin
      n_fail++;
      $display("FAIL busy_start_count: got writes=%0d done_cnt=%0d post_busy=%0d expected %0d 1 0",
               obs_q.size(), done_cnt, post_busy, exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL busy_start_pix%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    build_exp(320, 240, 2, 1, 10);
    run_cmd(320, 240, 2, 1, 10, 0, -1);
    n_checks++;
    if (obs_q.size() !== 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] || post_busy !== 0) begin
      n_fail++;
      $display("FAIL b2b_first: got writes=%0d post_busy=%0d expected 2 0 (start in done ignored)",
               obs_q.size(), post_busy);
    end
    build_exp(1, 479, 2, 9, 1);
    run_cmd(1, 479, 2, 9, 1, 0, 0);
    n_checks++;
    if (obs_q.size() !== 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] || done_cyc !== 4) begin
      n_fail++;
      $display("FAIL b2b_second: got writes=%0d done_cyc=%0d expected 2 4", obs_q.size(), done_cyc);
    end
  endtask

  task automatic test_random();
    int x, y, w, h, c;
    int bad;
    for (int t = 0; t < 25; t++) begin
      x = (t % 3 == 0) ? $urandom_range(630, 660) : $urandom_range(0, 639);
      y = (t % 4 == 0) ? $urandom_range(474, 490) : $urandom_range(0, 479);
      w = $urandom_range(0, 7);
      h = $urandom_range(0, 4);
      c = $urandom_range(0, 15);
      build_exp(x, y, w, h, c);
      run_cmd(x, y, w, h, c, 2, 0);
      bad = 0;
      foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0 || obs_q.size() !== exp_q.size() || gnt_viol !== 0 || idle_viol !== 0) begin
        n_fail++;
        $display("FAIL rand%0d (%0d,%0d,%0d,%0d): got writes=%0d bad=%0d gnt_viol=%0d idle_viol=%0d expected %0d 0 0 0",
                 t, x, y, w, h, obs_q.size(), bad, gnt_viol, idle_viol, exp_q.size());
      end
      n_checks++;
      if (done_cnt !== 1 || (exp_q.size() == 0 && done_cyc !== 2) ||
          (exp_q.size() != 0 && obs_cyc.size() != 0 && done_cyc !== obs_cyc[obs_cyc.size() - 1] + 1)) begin
        n_fail++; $display("FAIL rand%0d_done: got done_cyc=%0d cnt=%0d", t, done_cyc, done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    x0 = 10'd0; y0 = 10'd0; width = 10'd10; height = 10'd10; color = 4'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; sram_gnt = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sram_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_we: got %b expected 0", sram_we);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got busy=%b done=%b expected 0 0", busy, done);
    end
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || sram_we || busy) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", stray);
    end
    run_cmd(639, 0, 1, 1, 12, 0, 0);
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== {20'd639, 4'd12} || done_cyc !== 3) begin
      n_fail++;
      $display("FAIL rst_mid_refill: got writes=%0d first=%h done_cyc=%0d expected 1 %h 3",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 24'h0, done_cyc, {20'd639, 4'd12});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_throttle();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Rectangle-fill blitter: the write side of the VGA framebuffer SRAM.
- Takes a command (origin, size, 4-bit palette index) and writes that index into every covered pixel.
- Addressing matches the scan-out reader: addr = y*640 + x, 4-bit palette data per pixel.
- Sits between game/control logic and the SRAM arbiter; writes only in cycles where the arbiter grants the bus.

Parameters:
- H_RES, 640, visible pixels per line; also the row stride. Row base is computed as (y<<9)+(y<<7), so H_RES is fixed at 640.
- V_RES, 480, visible lines.

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- x0  in  10  rectangle left column
- y0  in  10  rectangle top row
- width  in  10  columns to fill
- height  in  10  rows to fill
- color  in  4  palette index to write (0=black … 0xA=grey)
- sram_gnt  in  1  arbiter grant; write permitted this cycle
- busy  out  1  command in progress (SETUP or WRITE)
- done  out  1  one-cycle completion pulse
- sram_we  out  1  write strobe; one pixel per asserted cycle
- sram_addr  out  20  pixel address
- sram_data  out  4  palette index to write

Behaviour:
- States: IDLE, SETUP, WRITE, DONE. Reset forces IDLE and clears all registers.
- Output decode:
  - busy = SETUP|WRITE.
  - done = (state==DONE).
  - sram_we = (state==WRITE) & sram_gnt & ~Reset.
  - sram_addr = sram_we ? row_base+cur_x : 0.
  - sram_data = sram_we ? latched color : 0.
  - All outputs are 0 during and immediately after reset.
- IDLE:
  - start=1 at an edge latches x0, y0, width, height, color, then goes to SETUP.
  - busy rises in the next cycle.
  - start in any other state is ignored; no queuing.
- SETUP (exactly 1 cycle):
  - Compute x_end = min(x0+width, H_RES) and y_end = min(y0+height, V_RES) in 11-bit arithmetic, so there is no overflow.
  - Empty case: if width==0, height==0, x0>=H_RES or y0>=V_RES, go to DONE with no writes.
  - Otherwise: cur_x=x0, cur_y=y0, row_base=(y0<<9)+(y0<<7), then go to WRITE.
- WRITE:
  - Cycle with sram_gnt=1: one pixel is written at the current address. At the edge:
    - If cur_x==x_end-1 and cur_y==y_end-1: go to DONE.
    - Else if cur_x==x_end-1: cur_x=x0, cur_y+=1, row_base+=640.
    - Else: cur_x+=1.
  - Cycle with sram_gnt=0: sram_we=0 and all counters hold. Grant may toggle arbitrarily without losing or duplicating pixels.
  - Write order is row-major, left to right, top to bottom.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start seen during DONE is ignored.
- Latency:
  - start sampled at edge N: SETUP occupies cycle N+1, and with continuous grant the first write is in cycle N+2.
  - With continuous grant, a w*h clipped rectangle takes w*h write cycles.
  - done is high in the cycle after the last write.
  - Empty command: done in cycle N+2.
- Clipping:
  - Pixels with x>=640 or y>=480 are never written.
  - Maximum address is 307199, which fits in 20 bits.
- Reset mid-operation:
  - sram_we is low in the reset cycle itself.
  - Next state is IDLE, the command is discarded, done is not pulsed.

Test Plan:
- Reset, then start with x0=10, y0=20, w=2, h=2, color=5, sram_gnt=1:
  - sram_we high for 4 consecutive cycles starting 2 cycles after start, at addrs 12810, 12811, 13450, 13451, data=5.
  - done pulses 1 cycle later; busy low thereafter.
- Clip: x0=638, y0=479, w=5, h=5, color=3 -> exactly 2 writes, addrs 307198 and 307199; then done.
- Empty: w=0 (also x0=700) -> sram_we never asserted; done high exactly 2 cycles after start accepted.
- Grant throttling: x0=0, y0=0, w=3, h=2, sram_gnt toggling 1,0,0,1,0,1… ->
  - exactly 6 writes, addrs 0, 1, 2, 640, 641, 642 in order;
  - sram_we=0 whenever gnt=0.
- Start while busy: second start (different color) mid-fill -> ignored; only the first command's pixels and color are written.
- Reset asserted mid-WRITE ->
  - sram_we=0 in that cycle; busy=0 next cycle; no done pulse.
  - A following 1x1 fill at (639,0) writes addr 639.
